// File: rtl/seq_code_lock_if.sv
// ---------------------------------------------------------------------------
// seq_code_lock_if
// Purpose : groups the board-facing signals of the sequential code lock so
//           the lock and whatever drives it share one bundle.
// Modports:
//   master : drives no / push1 / push2, observes the status outputs
//   slave  : the lock itself; samples the buttons, drives the status outputs
// Signals :
//   no       [WIDTH]  digit value from the switches
//   push1             enrol button (level, debounced)
//   push2             check button (level, debounced)
//   ledpin            lit after a fully matching check sequence
//   armed             a complete code is stored
//   locked            lockout in progress
//   idx      [IDX_W]  next digit position (enrol or check)
//   fail_cnt [FC_W]   consecutive failed checks
// ---------------------------------------------------------------------------
interface seq_code_lock_if #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter int MAX_FAIL = 3
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FC_W  = $clog2(MAX_FAIL + 1);

    logic [WIDTH-1:0] no;
    logic             push1;
    logic             push2;
    logic             ledpin;
    logic             armed;
    logic             locked;
    logic [IDX_W-1:0] idx;
    logic [FC_W-1:0]  fail_cnt;

    modport master (
        output no, push1, push2,
        input  ledpin, armed, locked, idx, fail_cnt
    );

    modport slave (
        input  no, push1, push2,
        output ledpin, armed, locked, idx, fail_cnt
    );
endinterface

// File: rtl/seq_code_lock.sv
// ---------------------------------------------------------------------------
// seq_code_lock
// Purpose : enrols a DEPTH-digit code (WIDTH bits per digit) on rising edges
//           of push1, verifies a re-entered sequence on rising edges of
//           push2 and lights ledpin on a full match.  Consecutive failed
//           checks are counted; with lockout enabled, MAX_FAIL failures
//           freeze the lock for LOCK_CYCLES clocks.
// Ports   :
//   clk  : system clock, all state changes on posedge
//   rst  : synchronous reset, active-high
//   bus  : seq_code_lock_if.slave (no, push1, push2 in;
//          ledpin, armed, locked, idx, fail_cnt out)
// Config  : define SEQ_CODE_LOCK_LOCKOUT_EN to build the LOCK state and its
//           timer.  Without it locked is tied low and fail_cnt saturates.
// ---------------------------------------------------------------------------
module seq_code_lock #(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst,
    seq_code_lock_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FC_W  = $clog2(MAX_FAIL + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [FC_W-1:0]  FC_ONE   = FC_W'(1);

`ifdef SEQ_CODE_LOCK_LOCKOUT_EN
    localparam int TMR_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(LOCK_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [FC_W-1:0]  FAIL_LIMIT = FC_W'(MAX_FAIL);

    typedef enum logic [1:0] {IDLE, ENROL, CHECK, LOCK} state_t;

    logic [TMR_W-1:0] timer_q, timer_d;
`else
    typedef enum logic [1:0] {IDLE, ENROL, CHECK} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] code_q [DEPTH];
    logic [WIDTH-1:0] code_d [DEPTH];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [FC_W-1:0]  fail_q, fail_d;
    logic             armed_q, armed_d;
    logic             led_q, led_d;
    logic             mism_q, mism_d;
    logic             push1_q, push2_q;

    logic             ev1, ev2;
    logic             cur_mism;
    logic [FC_W-1:0]  fail_inc;

    // Simultaneous rising edges cancel each other, so only a lone edge
    // counts as an event.
    assign ev1 = bus.push1 & ~push1_q & ~(bus.push2 & ~push2_q);
    assign ev2 = bus.push2 & ~push2_q & ~(bus.push1 & ~push1_q);

    // Next-state logic.  A check started from IDLE begins with a clean
    // mismatch flag, so the stored flag is only folded in while in CHECK.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        idx_d    = idx_q;
        fail_d   = fail_q;
        armed_d  = armed_q;
        led_d    = led_q;
        mism_d   = mism_q;
`ifdef SEQ_CODE_LOCK_LOCKOUT_EN
        timer_d  = timer_q;
        fail_inc = fail_q + FC_ONE;
`else
        fail_inc = (fail_q == {FC_W{1'b1}}) ? fail_q : fail_q + FC_ONE;
`endif
        cur_mism = ((state_q == CHECK) & mism_q) | (bus.no != code_q[idx_q]);

        case (state_q)
            IDLE, CHECK: begin
                if (ev1) begin
                    code_d[0] = bus.no;
                    led_d     = 1'b0;
                    mism_d    = 1'b0;
                    if (DEPTH == 1) begin
                        armed_d = 1'b1;
                        idx_d   = '0;
                        fail_d  = '0;
                        state_d = IDLE;
                    end else begin
                        armed_d = 1'b0;
                        idx_d   = IDX_ONE;
                        state_d = ENROL;
                    end
                end else if (ev2 && (state_q == CHECK || armed_q)) begin
                    led_d = 1'b0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        mism_d  = 1'b0;
                        state_d = IDLE;
                        if (!cur_mism) begin
                            led_d  = 1'b1;
                            fail_d = '0;
                        end else begin
                            fail_d = fail_inc;
`ifdef SEQ_CODE_LOCK_LOCKOUT_EN
                            if (fail_inc == FAIL_LIMIT) begin
                                state_d = LOCK;
                                timer_d = TMR_LOAD;
                            end
`endif
                        end
                    end else begin
                        mism_d  = cur_mism;
                        idx_d   = idx_q + IDX_ONE;
                        state_d = CHECK;
                    end
                end
            end

            ENROL: begin
                if (ev1) begin
                    code_d[idx_q] = bus.no;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        armed_d = 1'b1;
                        fail_d  = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end

`ifdef SEQ_CODE_LOCK_LOCKOUT_EN
            // Events are ignored here; the lock releases on the cycle the
            // timer would reach zero, giving exactly LOCK_CYCLES locked cycles.
            LOCK: begin
                timer_d = timer_q - TMR_ONE;
                if (timer_q <= TMR_ONE) begin
                    timer_d = '0;
                    fail_d  = '0;
                    state_d = IDLE;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    // State register; button history is tracked every cycle so a button
    // held through a lockout does not fire when the lock releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                code_q[i] <= '0;
            end
            idx_q   <= '0;
            fail_q  <= '0;
            armed_q <= 1'b0;
            led_q   <= 1'b0;
            mism_q  <= 1'b0;
            push1_q <= 1'b0;
            push2_q <= 1'b0;
`ifdef SEQ_CODE_LOCK_LOCKOUT_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            fail_q  <= fail_d;
            armed_q <= armed_d;
            led_q   <= led_d;
            mism_q  <= mism_d;
            push1_q <= bus.push1;
            push2_q <= bus.push2;
`ifdef SEQ_CODE_LOCK_LOCKOUT_EN
            timer_q <= timer_d;
`endif
        end
    end

    assign bus.ledpin   = led_q;
    assign bus.armed    = armed_q;
    assign bus.idx      = idx_q;
    assign bus.fail_cnt = fail_q;
`ifdef SEQ_CODE_LOCK_LOCKOUT_EN
    assign bus.locked   = (state_q == LOCK);
`else
    assign bus.locked   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_code_lock.sv
// ---------------------------------------------------------------------------
// tb_seq_code_lock
// Purpose : directed bench for seq_code_lock (WIDTH=4, DEPTH=4, MAX_FAIL=3,
//           LOCK_CYCLES=16).  Each driven cycle pushes the expected outputs
//           of a behavioural model into a queue; the entry is popped and
//           compared one step after the following posedge.
// ---------------------------------------------------------------------------
module tb_seq_code_lock;
    localparam int WIDTH       = 4;
    localparam int DEPTH       = 4;
    localparam int MAX_FAIL    = 3;
    localparam int LOCK_CYCLES = 16;

    logic clk;
    logic rst;

    seq_code_lock_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_FAIL(MAX_FAIL)) bus ();

    seq_code_lock #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_count  = 0;
    int miscompare = 0;

    // Expected output word: {ledpin, armed, locked, idx[1:0], fail_cnt[1:0]}.
    logic [6:0] exp_q[$];

    // Behavioural model state: 0 idle, 1 enrol, 2 check, 3 lock.
    int         m_st;
    int         m_idx;
    int         m_fail;
    int         m_timer;
    bit         m_armed, m_led, m_mism, m_p1, m_p2;
    logic [3:0] m_code [4];

    task automatic model_step(input bit r, input bit p1, input bit p2, input logic [3:0] d);
        bit e1, e2;
        if (r) begin
            m_st = 0; m_idx = 0; m_fail = 0; m_timer = 0;
            m_armed = 0; m_led = 0; m_mism = 0; m_p1 = 0; m_p2 = 0;
            for (int i = 0; i < 4; i++) m_code[i] = 4'h0;
            return;
        end
        e1 = p1 && !m_p1;
        e2 = p2 && !m_p2;
        m_p1 = p1;
        m_p2 = p2;
        if (m_st == 3) begin
            m_timer--;
            if (m_timer == 0) begin
                m_st = 0;
                m_fail = 0;
            end
        end else if (e1 && !e2) begin
            if (m_st == 1) begin
                m_code[m_idx] = d;
                m_idx++;
                if (m_idx == DEPTH) begin
                    m_idx = 0; m_armed = 1; m_fail = 0; m_st = 0;
                end
            end else begin
                m_code[0] = d; m_led = 0; m_armed = 0; m_idx = 1; m_st = 1;
            end
        end else if (e2 && !e1 && (m_st == 2 || (m_st == 0 && m_armed))) begin
            if (m_st == 0) begin
                m_mism = 0; m_led = 0; m_st = 2;
            end
            if (d != m_code[m_idx]) m_mism = 1;
            m_idx++;
            if (m_idx == DEPTH) begin
                m_idx = 0;
                m_st = 0;
                if (!m_mism) begin
                    m_led = 1; m_fail = 0;
                end else begin
                    m_led = 0;
`ifdef SEQ_CODE_LOCK_LOCKOUT_EN
                    m_fail++;
                    if (m_fail == MAX_FAIL) begin
                        m_st = 3; m_timer = LOCK_CYCLES;
                    end
`else
                    if (m_fail < 3) m_fail++;
`endif
                end
            end
        end
    endtask

    string phase = "init";

    // Pops the oldest expectation and compares it with the live outputs.
    task automatic checkOutput();
        logic [6:0] obs;
        logic [6:0] expv;
        obs = {bus.ledpin, bus.armed, bus.locked, bus.idx, bus.fail_cnt};
        vec_count++;
        if (exp_q.size() == 0) begin
            miscompare++;
            $error("[TB] FAIL scoreboard_empty (%s) observed=%b expected=<entry>", phase, obs);
            return;
        end
        expv = exp_q.pop_front();
        assert (obs === expv) else begin
            miscompare++;
            $error("[TB] FAIL %s observed=%b expected=%b", phase, obs, expv);
        end
    endtask

    // Directed check of one output field against a literal expectation.
    task automatic checkConst(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        vec_count++;
        assert (obs === expv) else begin
            miscompare++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Drives one cycle of inputs, records the model's prediction, then
    // compares after the posedge.
    task automatic applyStimulus(input bit r, input bit p1, input bit p2, input logic [3:0] d);
        @(negedge clk);
        rst       = r;
        bus.push1 = p1;
        bus.push2 = p2;
        bus.no    = d;
        model_step(r, p1, p2, d);
        exp_q.push_back({m_led, m_armed, (m_st == 3), 2'(m_idx), 2'(m_fail)});
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // One button press held for 'hold' cycles followed by a release cycle.
    task automatic press(input bit which, input logic [3:0] d, input int hold);
        for (int i = 0; i < hold; i++) applyStimulus(0, !which, which, d);
        applyStimulus(0, 0, 0, d);
    endtask

    // Four presses of one button; digits[15:12] goes first.
    task automatic enter4(input bit which, input logic [15:0] digits);
        logic [15:0] v;
        v = digits;
        for (int i = 0; i < 4; i++) begin
            press(which, v[15:12], 2);
            v = v << 4;
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.push1 = 1'b0;
        bus.push2 = 1'b0;
        bus.no    = 4'h0;

        phase = "reset";
        applyStimulus(1, 0, 0, 4'h0);
        applyStimulus(1, 0, 0, 4'h0);
        applyStimulus(0, 0, 0, 4'h0);
        applyStimulus(0, 0, 0, 4'h0);
        checkConst("reset_outputs", {bus.ledpin, bus.armed, bus.locked, bus.idx, bus.fail_cnt}, 7'b0);

        phase = "enrol";
        enter4(0, 16'hAB35);
        checkConst("enrol_armed", {6'b0, bus.armed}, 7'd1);
        phase = "match";
        enter4(1, 16'hAB35);
        checkConst("match_led", {6'b0, bus.ledpin}, 7'd1);

        phase = "mismatch";
        enter4(1, 16'hAA35);
        checkConst("mismatch_led_idx_fail", {bus.ledpin, bus.idx, bus.fail_cnt}, {1'b0, 2'd0, 2'd1});
        phase = "recheck";
        enter4(1, 16'hAB35);
        checkConst("recheck_led_fail", {bus.ledpin, bus.fail_cnt}, {1'b1, 2'd0});

        phase = "wrong_checks";
        enter4(1, 16'h1111);
        enter4(1, 16'h2222);
        press(1, 4'h3, 1);
        press(1, 4'h3, 1);
        press(1, 4'h3, 1);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 4'h3);
`ifdef SEQ_CODE_LOCK_LOCKOUT_EN
        checkConst("lock_entered", {6'b0, bus.locked}, 7'd1);
        phase = "lock_pushes";
        applyStimulus(0, 0, 0, 4'h3);
        for (int i = 0; i < 13; i++)
            applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 4'h0);
        checkConst("lock_released", {bus.armed, bus.locked, bus.fail_cnt}, {1'b1, 1'b0, 2'd0});
`else
        applyStimulus(0, 0, 0, 4'h3);
        checkConst("third_fail_no_lock", {bus.locked, bus.fail_cnt}, {1'b0, 2'd3});
        phase = "fail_saturate";
        enter4(1, 16'h4444);
        checkConst("fail_saturated", {bus.locked, bus.fail_cnt}, {1'b0, 2'd3});
`endif
        phase = "post_fail_check";
        enter4(1, 16'hAB35);
        checkConst("post_fail_led", {bus.ledpin, bus.fail_cnt}, {1'b1, 2'd0});

        phase = "abort";
        press(1, 4'hA, 2);
        press(1, 4'hB, 2);
        press(0, 4'h7, 2);
        checkConst("abort_idx_armed", {bus.armed, bus.idx, bus.fail_cnt}, {1'b0, 2'd1, 2'd0});
        phase = "simultaneous";
        applyStimulus(0, 1, 1, 4'h9);
        applyStimulus(0, 1, 1, 4'h9);
        applyStimulus(0, 0, 0, 4'h9);
        checkConst("simul_no_change", {bus.armed, bus.idx}, {1'b0, 2'd1});
        phase = "re_enrol";
        press(0, 4'h1, 2);
        press(0, 4'h2, 2);
        press(0, 4'h3, 2);
        phase = "held_push2";
        press(1, 4'h7, 10);
        checkConst("held_one_digit", {5'b0, bus.idx}, 7'd1);
        press(1, 4'h1, 2);
        press(1, 4'h2, 2);
        press(1, 4'h3, 2);
        checkConst("new_code_led", {6'b0, bus.ledpin}, 7'd1);

        phase = "reset_mid_enrol";
        press(0, 4'h5, 2);
        press(0, 4'h6, 2);
        applyStimulus(1, 0, 0, 4'h0);
        checkConst("mid_enrol_reset", {bus.ledpin, bus.armed, bus.locked, bus.idx, bus.fail_cnt}, 7'b0);
        phase = "e2_after_reset";
        press(1, 4'h5, 2);
        checkConst("e2_ignored", {bus.armed, bus.idx}, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
        $finish;
    end
endmodule

// File: doc/seq_code_lock.md
Name: seq_code_lock

Overview:
- Parametrised successor to the single-digit push-button compare block.
- Enrols a DEPTH-digit code of WIDTH-bit values from switches `no` on push1 presses.
- Verifies a re-entered sequence on push2 presses and drives ledpin on a full match.
- Adds edge-detected buttons, digit indexing, a failed-attempt counter and a timed lockout; sits between the debounced board inputs and the LED.

Parameters:
- WIDTH, 4: bits per digit (width of `no`).
- DEPTH, 4: digits per code, ≥1.
- MAX_FAIL, 3: consecutive failed checks that trigger lockout, ≥1.
- LOCK_CYCLES, 16: lockout duration in clk cycles, ≥1.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous reset, active-high.
- no  input  WIDTH  digit value from switches.
- push1  input  1  enrol button, level; a rising edge is one event.
- push2  input  1  check button, level; a rising edge is one event.
- ledpin  output  1  high after a fully matching check sequence.
- armed  output  1  a complete code is stored.
- locked  output  1  lockout active.
- idx  output  clog2(DEPTH) (min 1)  next digit position, enrol or check.
- fail_cnt  output  clog2(MAX_FAIL+1)  consecutive failed checks.

Behaviour:
- Reset (rst high at posedge): state=IDLE; ledpin=0, armed=0, locked=0, idx=0, fail_cnt=0; code storage cleared to 0; push1_q=push2_q=0. Reset overrides everything, including mid-sequence and lockout.
- Edge detect: e1 = push1 & ~push1_q, e2 = push2 & ~push2_q. push*_q are registered every cycle, including during lockout. A held button yields exactly one event. Each event is acted on at the same posedge it is first sampled: zero-cycle latency, registered outputs.
- e1 and e2 in the same cycle: both ignored; no state change except the push*_q update.
- States: IDLE, ENROL, CHECK, LOCK.
- IDLE:
  - e1: code[0]=no; ledpin=0; armed=0; idx=1; go to ENROL. If DEPTH==1: armed=1, idx=0, stay IDLE.
  - e2 with armed=1: run the CHECK digit rule at idx=0.
  - e2 with armed=0: ignored.
- ENROL on e1: code[idx]=no, idx+1. When idx reaches DEPTH: idx=0, armed=1, fail_cnt=0, go to IDLE. e2 in ENROL is ignored.
- CHECK digit rule on e2:
  - Set mism |= (no != code[idx]), then idx+1.
  - On the DEPTH-th digit: idx=0, go to IDLE, and
    - all matched: ledpin=1, fail_cnt=0;
    - else: ledpin=0, fail_cnt+1.
  - If fail_cnt becomes MAX_FAIL: go to LOCK, locked=1, load timer=LOCK_CYCLES.
  - Leaving IDLE for CHECK clears ledpin and mism.
- e1 in CHECK: abort the check, discard mism, with no fail increment. Start re-enrolment exactly as e1 from IDLE.
- LOCK:
  - All events are ignored; the timer decrements each cycle.
  - When the timer reaches 0: locked=0, fail_cnt=0, go to IDLE. The code is retained and armed stays 1.
- ledpin holds its value until the next accepted e1/e2 or reset.
- idx wraps only via the DEPTH rule above; it never exceeds DEPTH-1.

Optional Feature:
- Macro: SEQ_CODE_LOCK_LOCKOUT_EN.
- Defined: the LOCK state, timer and MAX_FAIL behaviour are as above.
- Undefined: no LOCK state or timer. locked is tied 0. fail_cnt still counts but saturates at its maximum, and checks are always accepted.

Test Plan:
- Reset then idle: rst 2 cycles, no pushes → ledpin=0, armed=0, locked=0, idx=0, fail_cnt=0.
- Enrol/match: e1 with no=A,B,3,5 (each push held ≥2 cycles), then e2 with A,B,3,5 → armed=1 after the 4th e1. ledpin=1 at the posedge of the 4th e2; fail_cnt=0.
- Mismatch: code A,B,3,5; check A,A,3,5 → ledpin=0, fail_cnt=1, idx=0. A following correct check sets ledpin=1 and fail_cnt=0.
- Lockout (EN defined): 3 wrong checks → locked=1 on the 3rd final e2. Pushes during the next 16 cycles have no effect. Then locked=0, fail_cnt=0, armed=1, and a correct check lights ledpin.
- Abort/simultaneous: mid-check (idx=2) e1 with no=7 → idx=1, armed=0, fail_cnt unchanged. Simultaneous push1/push2 rising → no change. Holding push2 for 10 cycles counts as one digit.
- Reset mid-enrol: after 2 e1 digits, assert rst → all outputs 0. An e2 afterwards is ignored (armed=0).
